// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_pkg: shared widths, reset PC and FSM state type for the fetch unit   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  // PC register reset value; the first +2 step lands the first fetch on 0x00.
  localparam logic [ADDR_W-1:0] PC_RESET = 8'hFE;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_HI = 2'd1,
    FETCH_LO = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_slot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_slot: one-entry {instr, pc, valid} holding register, clear over load |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_slot #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;

  // Clear only drops valid; stale data is harmless while invalid.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (i_clear) begin
      valid_d = 1'b0;
    end else if (i_load) begin
      instr_d = i_instr;
      pc_d    = i_pc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign o_instr = instr_q;
  assign o_pc    = pc_q;
  assign o_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_fetch: two-byte instruction fetch from byte memory, valid/ready out  |
// | Option: INSTR_FETCH_PREFETCH_EN adds a one-entry prefetch slot             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module instr_fetch #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [ADDR_W-1:0]  PC_in,
  input  logic               EN_L,
  input  logic               FLUSH,
  output logic               MEM_REQ,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  input  logic               MEM_ACK,
  input  logic [7:0]         MEM_RDATA,
  output logic [INSTR_W-1:0] IR_OUT,
  output logic [ADDR_W-1:0]  IR_PC,
  output logic               IR_VALID,
  input  logic               IR_READY,
  output logic               PC_ADV_L,
  output logic               MISALIGN
);

  import fetch_pkg::*;

  localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        hi_q, hi_d;
  logic              req_q, req_d;
  logic              adv_l_q, adv_l_d;
  logic              misalign_q, misalign_d;
  logic              discard_q, discard_d;

  logic               w_xfer, w_fill, w_start, w_slot_free;
  logic               w_out_load, w_out_clear;
  logic [INSTR_W-1:0] w_fill_instr, w_out_instr;
  logic [ADDR_W-1:0]  w_out_pc;

  assign w_xfer       = IR_VALID && IR_READY;
  assign w_fill       = (state_q == FETCH_LO) && MEM_ACK && !discard_q && !FLUSH;
  assign w_start      = !EN_L && !FLUSH && w_slot_free && !PC_in[0];
  assign w_fill_instr = {hi_q, MEM_RDATA};

`ifdef INSTR_FETCH_PREFETCH_EN
  logic               w_pf_load, w_pf_clear, w_pf_valid;
  logic [INSTR_W-1:0] w_pf_instr;
  logic [ADDR_W-1:0]  w_pf_pc;

  // A fetch only starts with the prefetch slot empty, so a fill never meets a full slot.
  assign w_slot_free = !w_pf_valid || w_xfer;
  assign w_pf_load   = w_fill && IR_VALID && !w_xfer;
  assign w_pf_clear  = FLUSH || (w_xfer && w_pf_valid);
  assign w_out_load  = !FLUSH && ((w_xfer && w_pf_valid) || (w_fill && (!IR_VALID || w_xfer)));
  assign w_out_instr = w_pf_valid ? w_pf_instr : w_fill_instr;
  assign w_out_pc    = w_pf_valid ? w_pf_pc : pc_q;

  fetch_slot #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_pf_slot (
    .clk     (CLK),
    .rst     (RESET),
    .i_load  (w_pf_load),
    .i_clear (w_pf_clear),
    .i_instr (w_fill_instr),
    .i_pc    (pc_q),
    .o_instr (w_pf_instr),
    .o_pc    (w_pf_pc),
    .o_valid (w_pf_valid)
  );
`else
  assign w_slot_free = !IR_VALID || w_xfer;
  assign w_out_load  = w_fill;
  assign w_out_instr = w_fill_instr;
  assign w_out_pc    = pc_q;
`endif

  assign w_out_clear = FLUSH || (w_xfer && !w_out_load);

  fetch_slot #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_out_slot (
    .clk     (CLK),
    .rst     (RESET),
    .i_load  (w_out_load),
    .i_clear (w_out_clear),
    .i_instr (w_out_instr),
    .i_pc    (w_out_pc),
    .o_instr (IR_OUT),
    .o_pc    (IR_PC),
    .o_valid (IR_VALID)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    req_d      = req_q;
    adv_l_d    = 1'b1;
    misalign_d = misalign_q;
    discard_d  = discard_q;
    case (state_q)
      IDLE: begin
        if (!EN_L && PC_in[0]) misalign_d = 1'b1;
        if (w_start) begin
          state_d = FETCH_HI;
          pc_d    = PC_in;
          addr_d  = PC_in;
          req_d   = 1'b1;
        end
      end
      FETCH_HI: begin
        if (FLUSH) discard_d = 1'b1;
        if (MEM_ACK) begin
          hi_d    = MEM_RDATA;
          addr_d  = pc_q + c_one;
          state_d = FETCH_LO;
        end
      end
      FETCH_LO: begin
        if (FLUSH) discard_d = 1'b1;
        // Discarded data returns to IDLE without advancing the PC.
        if (MEM_ACK) begin
          req_d     = 1'b0;
          discard_d = 1'b0;
          adv_l_d   = !w_fill;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      addr_q     <= '0;
      hi_q       <= '0;
      req_q      <= 1'b0;
      adv_l_q    <= 1'b1;
      misalign_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      req_q      <= req_d;
      adv_l_q    <= adv_l_d;
      misalign_q <= misalign_d;
      discard_q  <= discard_d;
    end
  end

  assign MEM_REQ  = req_q;
  assign MEM_ADDR = addr_q;
  assign PC_ADV_L = adv_l_q;
  assign MISALIGN = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_fetch: directed self-checking bench for instr_fetch               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_instr_fetch;

  import fetch_pkg::*;

  logic               CLK = 1'b0;
  logic               RESET;
  logic [ADDR_W-1:0]  PC_in;
  logic               EN_L;
  logic               FLUSH;
  logic               MEM_REQ;
  logic [ADDR_W-1:0]  MEM_ADDR;
  logic               MEM_ACK;
  logic [7:0]         MEM_RDATA;
  logic [INSTR_W-1:0] IR_OUT;
  logic [ADDR_W-1:0]  IR_PC;
  logic               IR_VALID;
  logic               IR_READY;
  logic               PC_ADV_L;
  logic               MISALIGN;

  logic [7:0] mem [256];
  logic       hold_ack;
  logic       exp_req [5];
  int         n_cmp  = 0;
  int         n_fail = 0;

  instr_fetch dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .PC_in     (PC_in),
    .EN_L      (EN_L),
    .FLUSH     (FLUSH),
    .MEM_REQ   (MEM_REQ),
    .MEM_ADDR  (MEM_ADDR),
    .MEM_ACK   (MEM_ACK),
    .MEM_RDATA (MEM_RDATA),
    .IR_OUT    (IR_OUT),
    .IR_PC     (IR_PC),
    .IR_VALID  (IR_VALID),
    .IR_READY  (IR_READY),
    .PC_ADV_L  (PC_ADV_L),
    .MISALIGN  (MISALIGN)
  );

  always #5 CLK = ~CLK;

  // Zero-wait memory unless the bench holds the ack off.
  assign MEM_ACK   = MEM_REQ && !hold_ack;
  assign MEM_RDATA = mem[MEM_ADDR];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RESET    = 1'b1;
    EN_L     = 1'b1;
    PC_in    = '0;
    FLUSH    = 1'b0;
    IR_READY = 1'b0;
    hold_ack = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
    mem[8'h02] = 8'h56; mem[8'h03] = 8'h78;
    mem[8'h04] = 8'h9A; mem[8'h05] = 8'hBC;
    mem[8'h06] = 8'hDE; mem[8'h07] = 8'hF0;
    mem[8'h08] = 8'h11; mem[8'h09] = 8'h22;
    mem[8'hFE] = 8'hAB; mem[8'hFF] = 8'hCD;
`ifdef INSTR_FETCH_PREFETCH_EN
    exp_req = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    exp_req = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state
    tick();
    tick();
    check("rst_req",      32'(MEM_REQ),  0);
    check("rst_addr",     32'(MEM_ADDR), 0);
    check("rst_ir_out",   32'(IR_OUT),   0);
    check("rst_ir_pc",    32'(IR_PC),    0);
    check("rst_valid",    32'(IR_VALID), 0);
    check("rst_adv_l",    32'(PC_ADV_L), 1);
    check("rst_misalign", 32'(MISALIGN), 0);
    RESET = 1'b0;
    tick();

    // Zero-wait fetch at the first PC after reset
    PC_in = PC_RESET + 8'd2;
    EN_L  = 1'b0;
    tick();
    check("t1_req_hi",  32'(MEM_REQ),  1);
    check("t1_addr_hi", 32'(MEM_ADDR), 'h00);
    EN_L = 1'b1;
    tick();
    check("t1_addr_lo",  32'(MEM_ADDR), 'h01);
    check("t1_req_lo",   32'(MEM_REQ),  1);
    check("t1_valid_lo", 32'(IR_VALID), 0);
    check("t1_adv_lo",   32'(PC_ADV_L), 1);
    tick();
    check("t1_req_done", 32'(MEM_REQ),  0);
    check("t1_valid",    32'(IR_VALID), 1);
    check("t1_ir_out",   32'(IR_OUT),   'h1234);
    check("t1_ir_pc",    32'(IR_PC),    'h00);
    check("t1_adv_low",  32'(PC_ADV_L), 0);
    tick();
    check("t1_adv_high", 32'(PC_ADV_L), 1);
    check("t1_hold",     32'(IR_VALID), 1);
    IR_READY = 1'b1;
    tick();
    check("t1_xfer", 32'(IR_VALID), 0);
    IR_READY = 1'b0;

    // Hi-byte ack delayed by 3 cycles
    hold_ack = 1'b1;
    PC_in    = 8'h00;
    EN_L     = 1'b0;
    tick();
    EN_L = 1'b1;
    check("t2_req_c0",  32'(MEM_REQ),  1);
    check("t2_addr_c0", 32'(MEM_ADDR), 'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_req_wait",  32'(MEM_REQ),  1);
      check("t2_addr_wait", 32'(MEM_ADDR), 'h00);
    end
    hold_ack = 1'b0;
    tick();
    check("t2_addr_lo", 32'(MEM_ADDR), 'h01);
    check("t2_valid_0", 32'(IR_VALID), 0);
    tick();
    check("t2_valid_1", 32'(IR_VALID), 1);
    check("t2_ir_out",  32'(IR_OUT),   'h1234);
    IR_READY = 1'b1;
    tick();
    IR_READY = 1'b0;

    // Address wrap at the top of memory
    PC_in = 8'hFE;
    EN_L  = 1'b0;
    tick();
    EN_L = 1'b1;
    check("t3_addr_hi", 32'(MEM_ADDR), 'hFE);
    tick();
    check("t3_addr_lo", 32'(MEM_ADDR), 'hFF);
    tick();
    check("t3_valid",  32'(IR_VALID), 1);
    check("t3_ir_out", 32'(IR_OUT),   'hABCD);
    check("t3_ir_pc",  32'(IR_PC),    'hFE);
    IR_READY = 1'b1;
    tick();
    IR_READY = 1'b0;

    // Misaligned PC: sticky flag, no request
    PC_in = 8'h05;
    EN_L  = 1'b0;
    tick();
    check("t3_misalign",   32'(MISALIGN), 1);
    check("t3_mis_no_req", 32'(MEM_REQ),  0);
    tick();
    check("t3_mis_no_req2", 32'(MEM_REQ), 0);
    EN_L  = 1'b1;
    PC_in = 8'h00;
    tick();
    check("t3_mis_sticky", 32'(MISALIGN), 1);

    // Decoder stall for 5 cycles
    PC_in = 8'h02;
    EN_L  = 1'b0;
    tick();
    tick();
    tick();
    check("t4_valid",  32'(IR_VALID), 1);
    check("t4_ir_out", 32'(IR_OUT),   'h5678);
    PC_in = 8'h04;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_stall_out", 32'(IR_OUT),  'h5678);
      check("t4_stall_req", 32'(MEM_REQ), 32'(exp_req[i]));
    end
`ifdef INSTR_FETCH_PREFETCH_EN
    EN_L     = 1'b1;
    IR_READY = 1'b1;
    tick();
    check("t4_b2b_valid", 32'(IR_VALID), 1);
    check("t4_b2b_out",   32'(IR_OUT),   'h9ABC);
    check("t4_b2b_pc",    32'(IR_PC),    'h04);
    tick();
    check("t4_drained", 32'(IR_VALID), 0);
`else
    IR_READY = 1'b1;
    tick();
    check("t4_xfer_valid", 32'(IR_VALID), 0);
    check("t4_xfer_req",   32'(MEM_REQ),  1);
    check("t4_xfer_addr",  32'(MEM_ADDR), 'h04);
    EN_L = 1'b1;
    tick();
    check("t4_addr_lo", 32'(MEM_ADDR), 'h05);
    tick();
    check("t4_next_valid", 32'(IR_VALID), 1);
    check("t4_next_out",   32'(IR_OUT),   'h9ABC);
    check("t4_next_pc",    32'(IR_PC),    'h04);
    tick();
    check("t4_drained", 32'(IR_VALID), 0);
`endif
    IR_READY = 1'b0;

    // FLUSH coincident with the lo-byte ack
    PC_in = 8'h06;
    EN_L  = 1'b0;
    tick();
    EN_L = 1'b1;
    tick();
    check("t5_in_lo", 32'(MEM_ADDR), 'h07);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("t5_req",   32'(MEM_REQ),  0);
    check("t5_valid", 32'(IR_VALID), 0);
    check("t5_adv",   32'(PC_ADV_L), 1);
    tick();
    check("t5_valid2", 32'(IR_VALID), 0);
    check("t5_adv2",   32'(PC_ADV_L), 1);
    PC_in = 8'h08;
    EN_L  = 1'b0;
    tick();
    EN_L = 1'b1;
    check("t5_new_addr", 32'(MEM_ADDR), 'h08);
    tick();
    tick();
    check("t5_new_valid", 32'(IR_VALID), 1);
    check("t5_new_out",   32'(IR_OUT),   'h1122);
    check("t5_new_pc",    32'(IR_PC),    'h08);

    // Asynchronous reset in the middle of FETCH_HI
    IR_READY = 1'b1;
    EN_L     = 1'b0;
    PC_in    = 8'h00;
    hold_ack = 1'b1;
    tick();
    IR_READY = 1'b0;
    EN_L     = 1'b1;
    check("t6_in_hi",       32'(MEM_REQ),  1);
    check("t6_mis_pre_rst", 32'(MISALIGN), 1);
    #2;
    RESET = 1'b1;
    #1;
    check("t6_req",      32'(MEM_REQ),  0);
    check("t6_valid",    32'(IR_VALID), 0);
    check("t6_ir_out",   32'(IR_OUT),   0);
    check("t6_ir_pc",    32'(IR_PC),    0);
    check("t6_addr",     32'(MEM_ADDR), 0);
    check("t6_misalign", 32'(MISALIGN), 0);
    @(posedge CLK);
    #1;
    RESET    = 1'b0;
    hold_ack = 1'b0;
    EN_L     = 1'b0;
    tick();
    EN_L = 1'b1;
    check("t6_idle_req",  32'(MEM_REQ),  1);
    check("t6_idle_addr", 32'(MEM_ADDR), 'h00);
    tick();
    tick();
    check("t6_refetch_valid", 32'(IR_VALID), 1);
    check("t6_refetch_out",   32'(IR_OUT),   'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
